controlador_rega: RTL and testbench
===================================

# controlador_rega

Sequencing controller for the irrigation subsystem: a Moore FSM that fills the tank, runs one sprinkler (aspersão) or drip (gotejamento) irrigation cycle per request, follows each cycle with a timed cleaning phase, and traps faults. It drives the fill valve, the 2-bit irrigation actuator bus, the cleaning flag and the 2-bit state code `mef1` consumed by the downstream irrigation validator. Encoding guarantees `mef1 == 2'b11` only while irrigating.

## Interface
- `TW`, 16: width of the shared phase timer.
- `T_REGA`, 200: irrigation phase length in cycles (1 ≤ value < 2^TW).
- `T_LIMPEZA`, 50: cleaning phase length in cycles (1 ≤ value < 2^TW).
- `T_ENCH`, 1000: fill timeout in cycles (1 ≤ value < 2^TW).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `nivel_baixo`  in  1  1 = water at or above the low sensor.
- `nivel_alto`  in  1  1 = water at or above the high sensor.
- `asp_req`  in  1  request sprinkler cycle (level-sampled).
- `got_req`  in  1  request drip cycle (level-sampled).
- `reconhece`  in  1  operator acknowledge; clears the error state.
- `ve`  out  1  fill valve open.
- `rega`  out  2  [1] = sprinkler on, [0] = drip on; never 2'b11.
- `limpeza`  out  1  cleaning phase active.
- `mef1`  out  2  state code: 00 OCIOSO, 01 ENCHENDO, 10 LIMPANDO, 11 REGANDO; 00 in ERRO.
- `erro`  out  1  fault state active.
- `erro_cod`  out  2  01 inconsistent level sensors, 10 fill timeout, 11 double request; 00 when no fault.

## Operation
- States: OCIOSO, ENCHENDO, REGANDO, LIMPANDO, ERRO. Phase timer `cnt[TW-1:0]`. Latched mode register `modo[1:0]`.
- Global rule, highest priority, every state except ERRO: `nivel_alto & ~nivel_baixo` -> ERRO, `erro_cod = 01`.
- OCIOSO, in priority order: `~nivel_baixo` -> ENCHENDO, `cnt = T_ENCH-1`. Else `asp_req & got_req` -> ERRO, code 11. Else exactly one request -> REGANDO, `modo = {asp_req, got_req}`, `cnt = T_REGA-1`. Else stay.
- ENCHENDO: `ve = 1`. If `nivel_alto` -> OCIOSO. Else if `cnt == 0` -> ERRO, code 10. Else `cnt--`.
- REGANDO: `rega = modo`. Requests are ignored. If `~nivel_baixo` -> abort to ENCHENDO (`cnt = T_ENCH-1`, request dropped, no cleaning). Else if `cnt == 0` -> LIMPANDO, `cnt = T_LIMPEZA-1`. Else `cnt--`.
- LIMPANDO: `limpeza = 1`. If `cnt == 0` -> OCIOSO. Else `cnt--`. Level loss does not abort cleaning, except through the global sensor rule.
- ERRO: all actuators off, `erro = 1`, `erro_cod` held. Exit to OCIOSO only when `reconhece` is asserted and sensors are consistent in the same cycle. `erro_cod` clears on exit.
- All outputs are decoded from registered state and `modo` only (Moore). No input reaches an output combinationally.
- Reset value of every output is 0: `ve`, `rega`, `limpeza`, `mef1`, `erro`, `erro_cod`. State returns to OCIOSO, `cnt = 0`, `modo = 0`.

## Timing
- Input sampled at edge k: the state and outputs change after edge k. Response latency is 1 cycle.
- A requested irrigation phase asserts `rega` for exactly T_REGA cycles, then `limpeza` for exactly T_LIMPEZA cycles, then returns to OCIOSO. A new request can be accepted on the first OCIOSO edge.
- Fill timeout: ERRO is entered on the T_ENCH-th edge in ENCHENDO if `nivel_alto` has not been seen. `nivel_alto` sampled on that same edge wins, and the next state is OCIOSO.
- In the terminal REGANDO cycle (`cnt == 0`), a simultaneous `~nivel_baixo` takes priority and the next state is ENCHENDO.
- Asynchronous reset mid-phase: outputs go to 0 immediately, with no wait for an edge. After release, the first edge evaluates from OCIOSO.
- `reconhece` is level-sensitive. Holding it while entering ERRO causes exit on the next edge if sensors are consistent.

## Test plan
- Reset with T_REGA=8, T_LIMPEZA=4, T_ENCH=20: assert `rst_n=0` mid-REGANDO -> all outputs 0 asynchronously. Release -> `mef1 = 00`.
- Level full, pulse `asp_req` 1 cycle -> `rega = 10` and `mef1 = 11` for 8 cycles, then `limpeza = 1` and `mef1 = 10` for 4 cycles, then `mef1 = 00`. Repeat with `got_req` -> `rega = 01`.
- `nivel_baixo = 0` in OCIOSO -> `ve = 1`, `mef1 = 01`. Raise `nivel_baixo`/`nivel_alto` at cycle 10 -> `ve = 0` next cycle. Never raise them -> `erro = 1`, `erro_cod = 10` after exactly 20 cycles.
- `asp_req = got_req = 1` in OCIOSO -> `erro = 1`, `erro_cod = 11`, `rega = 00`. Pulse `reconhece` -> OCIOSO, `erro_cod = 00`.
- `nivel_alto = 1`, `nivel_baixo = 0` during LIMPANDO -> ERRO with code 01. `reconhece` while still inconsistent -> stays in ERRO. Fix sensors and apply `reconhece` -> OCIOSO.
- Drop `nivel_baixo` at REGANDO cycle 3 -> ENCHENDO next cycle, `rega = 00`, `ve = 1`, no LIMPANDO. Same drop on the terminal cycle (`cnt == 0`) -> ENCHENDO, not LIMPANDO.

Source files
------------

// File: rtl/controlador_rega.sv
// Irrigation sequencing controller: fill, one irrigation cycle per request, timed cleaning, fault trap.
// Moore FSM. Every output is registered and decoded from the next state, so no input reaches an output combinationally.
module controlador_rega #(
    parameter int TW        = 16,
    parameter int T_REGA    = 200,
    parameter int T_LIMPEZA = 50,
    parameter int T_ENCH    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nivel_baixo,
    input  logic       nivel_alto,
    input  logic       asp_req,
    input  logic       got_req,
    input  logic       reconhece,
    output logic       ve,
    output logic [1:0] rega,
    output logic       limpeza,
    output logic [1:0] mef1,
    output logic       erro,
    output logic [1:0] erro_cod
);

    typedef enum logic [2:0] {
        OCIOSO,
        ENCHENDO,
        REGANDO,
        LIMPANDO,
        ERRO
    } estado_t;

    localparam logic [TW-1:0] CNT_REGA    = TW'(T_REGA - 1);
    localparam logic [TW-1:0] CNT_LIMPEZA = TW'(T_LIMPEZA - 1);
    localparam logic [TW-1:0] CNT_ENCH    = TW'(T_ENCH - 1);

    localparam logic [1:0] COD_SENSOR  = 2'b01;
    localparam logic [1:0] COD_TIMEOUT = 2'b10;
    localparam logic [1:0] COD_DUPLO   = 2'b11;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    modo_q, modo_d;
    logic [1:0]    erro_cod_q, erro_cod_d;
    logic          ve_q, ve_d;
    logic [1:0]    rega_q, rega_d;
    logic          limpeza_q, limpeza_d;
    logic [1:0]    mef1_q, mef1_d;
    logic          erro_q, erro_d;

    logic sensor_incoerente;
    assign sensor_incoerente = nivel_alto & ~nivel_baixo;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        modo_d     = modo_q;
        erro_cod_d = erro_cod_q;

        if (estado_q != ERRO && sensor_incoerente) begin
            estado_d   = ERRO;
            erro_cod_d = COD_SENSOR;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (!nivel_baixo) begin
                        estado_d = ENCHENDO;
                        cnt_d    = CNT_ENCH;
                    end else if (asp_req && got_req) begin
                        estado_d   = ERRO;
                        erro_cod_d = COD_DUPLO;
                    end else if (asp_req || got_req) begin
                        estado_d = REGANDO;
                        modo_d   = {asp_req, got_req};
                        cnt_d    = CNT_REGA;
                    end
                end
                ENCHENDO: begin
                    if (nivel_alto) begin
                        estado_d = OCIOSO;
                    end else if (cnt_q == '0) begin
                        estado_d   = ERRO;
                        erro_cod_d = COD_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                REGANDO: begin
                    // Losing the low level aborts irrigation outright; the pending cycle is dropped.
                    if (!nivel_baixo) begin
                        estado_d = ENCHENDO;
                        cnt_d    = CNT_ENCH;
                    end else if (cnt_q == '0) begin
                        estado_d = LIMPANDO;
                        cnt_d    = CNT_LIMPEZA;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                LIMPANDO: begin
                    if (cnt_q == '0) begin
                        estado_d = OCIOSO;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                ERRO: begin
                    if (reconhece && !sensor_incoerente) begin
                        estado_d   = OCIOSO;
                        erro_cod_d = 2'b00;
                    end
                end
                default: begin
                    estado_d   = OCIOSO;
                    erro_cod_d = 2'b00;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copy lines up with estado_q.
    always_comb begin
        ve_d      = 1'b0;
        rega_d    = 2'b00;
        limpeza_d = 1'b0;
        mef1_d    = 2'b00;
        erro_d    = 1'b0;
        unique case (estado_d)
            ENCHENDO: begin
                ve_d   = 1'b1;
                mef1_d = 2'b01;
            end
            REGANDO: begin
                rega_d = modo_d;
                mef1_d = 2'b11;
            end
            LIMPANDO: begin
                limpeza_d = 1'b1;
                mef1_d    = 2'b10;
            end
            ERRO:    erro_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            modo_q     <= 2'b00;
            erro_cod_q <= 2'b00;
            ve_q       <= 1'b0;
            rega_q     <= 2'b00;
            limpeza_q  <= 1'b0;
            mef1_q     <= 2'b00;
            erro_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            modo_q     <= modo_d;
            erro_cod_q <= erro_cod_d;
            ve_q       <= ve_d;
            rega_q     <= rega_d;
            limpeza_q  <= limpeza_d;
            mef1_q     <= mef1_d;
            erro_q     <= erro_d;
        end
    end

    assign ve       = ve_q;
    assign rega     = rega_q;
    assign limpeza  = limpeza_q;
    assign mef1     = mef1_q;
    assign erro     = erro_q;
    assign erro_cod = erro_cod_q;

endmodule

// File: tb/tb_controlador_rega.sv
// Self-checking bench for controlador_rega: directed scenarios plus a random run checked
// against a phase/elapsed-time model of the irrigation sequence.
module tb_controlador_rega;

    localparam int TW        = 16;
    localparam int T_REGA    = 8;
    localparam int T_LIMPEZA = 4;
    localparam int T_ENCH    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nivel_baixo, nivel_alto, asp_req, got_req, reconhece;
    logic       ve, limpeza, erro;
    logic [1:0] rega, mef1, erro_cod;

    int errors = 0;
    int checks = 0;

    controlador_rega #(
        .TW(TW), .T_REGA(T_REGA), .T_LIMPEZA(T_LIMPEZA), .T_ENCH(T_ENCH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .nivel_baixo(nivel_baixo), .nivel_alto(nivel_alto),
        .asp_req(asp_req), .got_req(got_req), .reconhece(reconhece),
        .ve(ve), .rega(rega), .limpeza(limpeza),
        .mef1(mef1), .erro(erro), .erro_cod(erro_cod)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {ve, rega, limpeza, mef1, erro, erro_cod}.
    logic [8:0] obs;
    assign obs = {ve, rega, limpeza, mef1, erro, erro_cod};

    function automatic logic [8:0] o_idle();
        return 9'b0;
    endfunction
    function automatic logic [8:0] o_fill();
        return {1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    endfunction
    function automatic logic [8:0] o_irr(input logic [1:0] m);
        return {1'b0, m, 1'b0, 2'b11, 1'b0, 2'b00};
    endfunction
    function automatic logic [8:0] o_clean();
        return {1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00};
    endfunction
    function automatic logic [8:0] o_err(input logic [1:0] c);
        return {1'b0, 2'b00, 1'b0, 2'b00, 1'b1, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic nb, input logic na, input logic a, input logic g, input logic r);
        nivel_baixo = nb; nivel_alto = na; asp_req = a; got_req = g; reconhece = r;
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL reset_initial: got %b expected %b", obs, o_idle()); end
        #9 rst_n = 1'b1;
        set_in(1, 1, 1, 0, 0);
        tick();
        asp_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (obs !== o_irr(2'b10)) begin errors++; $display("FAIL reset_pre_irr: got %b expected %b", obs, o_irr(2'b10)); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL reset_async: got %b expected %b", obs, o_idle()); end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, o_idle()); end
    endtask

    task automatic test_irrigation(input logic a, input logic g);
        set_in(1, 1, a, g, 0);
        tick();
        asp_req = 1'b0; got_req = 1'b0;
        for (int i = 0; i < T_REGA; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== o_irr({a, g})) begin
                errors++; $display("FAIL irr_%b%b cycle %0d: got %b expected %b", a, g, i, obs, o_irr({a, g}));
            end
        end
        for (int i = 0; i < T_LIMPEZA; i++) begin
            tick();
            checks++;
            if (obs !== o_clean()) begin
                errors++; $display("FAIL clean_%b%b cycle %0d: got %b expected %b", a, g, i, obs, o_clean());
            end
        end
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL irr_end_%b%b: got %b expected %b", a, g, obs, o_idle()); end
    endtask

    task automatic test_fill();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== o_fill()) begin errors++; $display("FAIL fill cycle %0d: got %b expected %b", i, obs, o_fill()); end
        end
        set_in(1, 1, 0, 0, 0);
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL fill_done: got %b expected %b", obs, o_idle()); end
    endtask

    task automatic test_timeout();
        set_in(0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k < T_ENCH; k++) begin
            tick();
            checks++;
            if (obs !== o_fill()) begin errors++; $display("FAIL timeout_fill edge %0d: got %b expected %b", k, obs, o_fill()); end
        end
        tick();
        checks++;
        if (obs !== o_err(2'b10)) begin errors++; $display("FAIL timeout_err: got %b expected %b", obs, o_err(2'b10)); end
        set_in(1, 1, 0, 0, 1);
        tick();
        reconhece = 1'b0;
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL timeout_ack: got %b expected %b", obs, o_idle()); end
        // High level seen on the would-be timeout edge wins.
        set_in(0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k < T_ENCH; k++) tick();
        set_in(1, 1, 0, 0, 0);
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL timeout_race: got %b expected %b", obs, o_idle()); end
    endtask

    task automatic test_double();
        set_in(1, 1, 1, 1, 0);
        tick();
        tick();
        checks++;
        if (obs !== o_err(2'b11)) begin errors++; $display("FAIL double_err: got %b expected %b", obs, o_err(2'b11)); end
        set_in(1, 1, 0, 0, 1);
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL double_ack: got %b expected %b", obs, o_idle()); end
        // Acknowledge already held when the fault is entered.
        set_in(1, 1, 1, 1, 1);
        tick();
        checks++;
        if (obs !== o_err(2'b11)) begin errors++; $display("FAIL double_held_err: got %b expected %b", obs, o_err(2'b11)); end
        set_in(1, 1, 0, 0, 1);
        tick();
        reconhece = 1'b0;
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL double_held_ack: got %b expected %b", obs, o_idle()); end
    endtask

    task automatic test_sensor_err();
        set_in(1, 1, 1, 0, 0);
        tick();
        asp_req = 1'b0;
        for (int i = 0; i < T_REGA; i++) tick();
        checks++;
        if (obs !== o_clean()) begin errors++; $display("FAIL sensor_clean: got %b expected %b", obs, o_clean()); end
        set_in(0, 1, 0, 0, 0);
        tick();
        checks++;
        if (obs !== o_err(2'b01)) begin errors++; $display("FAIL sensor_err: got %b expected %b", obs, o_err(2'b01)); end
        reconhece = 1'b1;
        tick();
        checks++;
        if (obs !== o_err(2'b01)) begin errors++; $display("FAIL sensor_ack_bad: got %b expected %b", obs, o_err(2'b01)); end
        nivel_baixo = 1'b1;
        tick();
        reconhece = 1'b0;
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL sensor_ack_ok: got %b expected %b", obs, o_idle()); end
    endtask

    task automatic test_abort(input int drop_after);
        set_in(1, 1, 0, 1, 0);
        tick();
        got_req = 1'b0;
        for (int i = 0; i < drop_after; i++) tick();
        checks++;
        if (obs !== o_irr(2'b01)) begin errors++; $display("FAIL abort_pre %0d: got %b expected %b", drop_after, obs, o_irr(2'b01)); end
        set_in(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (obs !== o_fill()) begin errors++; $display("FAIL abort_fill %0d: got %b expected %b", drop_after, obs, o_fill()); end
        set_in(1, 1, 0, 0, 0);
        tick();
        checks++;
        if (obs !== o_idle()) begin errors++; $display("FAIL abort_idle %0d: got %b expected %b", drop_after, obs, o_idle()); end
    endtask

    // Reference model: phase plus cycles already spent in it.
    typedef enum int {P_IDLE, P_FILL, P_IRR, P_CLEAN, P_ERR} phase_t;

    task automatic test_random();
        phase_t     ph = P_IDLE;
        int         elapsed = 0;
        logic [1:0] mode = 2'b00;
        logic [1:0] code = 2'b00;
        logic [8:0] exp;
        logic       bad;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            nivel_baixo = ($urandom % 12) != 0;
            nivel_alto  = nivel_baixo ? (($urandom % 4) == 0) : (($urandom % 40) == 0);
            asp_req     = ($urandom % 6) == 0;
            got_req     = ($urandom % 6) == 0;
            reconhece   = ($urandom % 4) == 0;
            bad = nivel_alto && !nivel_baixo;
            if (ph != P_ERR && bad) begin
                ph = P_ERR; code = 2'b01;
            end else begin
                case (ph)
                    P_IDLE:
                        if (!nivel_baixo) begin ph = P_FILL; elapsed = 0; end
                        else if (asp_req && got_req) begin ph = P_ERR; code = 2'b11; end
                        else if (asp_req || got_req) begin ph = P_IRR; elapsed = 0; mode = {asp_req, got_req}; end
                    P_FILL:
                        if (nivel_alto) ph = P_IDLE;
                        else if (elapsed == T_ENCH - 1) begin ph = P_ERR; code = 2'b10; end
                        else elapsed++;
                    P_IRR:
                        if (!nivel_baixo) begin ph = P_FILL; elapsed = 0; end
                        else if (elapsed == T_REGA - 1) begin ph = P_CLEAN; elapsed = 0; end
                        else elapsed++;
                    P_CLEAN:
                        if (elapsed == T_LIMPEZA - 1) ph = P_IDLE;
                        else elapsed++;
                    default:
                        if (reconhece && !bad) begin ph = P_IDLE; code = 2'b00; end
                endcase
            end
            case (ph)
                P_FILL:  exp = o_fill();
                P_IRR:   exp = o_irr(mode);
                P_CLEAN: exp = o_clean();
                P_ERR:   exp = o_err(code);
                default: exp = o_idle();
            endcase
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_irrigation(1'b1, 1'b0);
        test_irrigation(1'b0, 1'b1);
        test_fill();
        test_timeout();
        test_double();
        test_sensor_err();
        test_abort(2);
        test_abort(T_REGA - 1);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
